// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, 1-cycle ROM handshake, prefetch FIFO feeding IF/ID.
// Optional IF_ADEL_CHECK_EN: misaligned PCs become address-error entries instead of ROM reads.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned PC_STEP   = 4,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
`ifdef IF_ADEL_CHECK_EN
  ,output logic       if_excp_adel_o
`endif
);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic [31:0]       pc_mem_q [BUF_DEPTH];
  logic [31:0]       pc_mem_d [BUF_DEPTH];
  logic [31:0]       inst_mem_q [BUF_DEPTH];
  logic [31:0]       inst_mem_d [BUF_DEPTH];

  logic              redirect, pop, push, fits, req, misalign;
  logic [CW-1:0]     occ_eff;
  logic [31:0]       req_pc, push_inst;
  logic              unused_stall;

  assign unused_stall = ^stall[5:2];

  assign redirect   = branch_flag_i && !flush_i;
  assign if_valid_o = (cnt_q != '0) && !flush_i;
  assign if_pc_o    = if_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign if_inst_o  = if_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign pop        = if_valid_o && !stall[1];
  // A response that lands during a redirect belongs to the old path.
  assign push       = inflight_q && !flush_i && !branch_flag_i;

  // A slot freed by this cycle's pop is reusable at once, so streaming has no gaps.
  assign occ_eff = cnt_q + CW'(inflight_q) - CW'(pop);
  assign fits    = occ_eff < CW'(BUF_DEPTH);
  assign req     = (state_q != IDLE) && !stall[0] && !flush_i && (redirect || fits);
  assign req_pc  = redirect ? branch_target_i : pc_q;

`ifdef IF_ADEL_CHECK_EN
  logic             inflight_adel_q, inflight_adel_d;
  logic             adel_mem_q [BUF_DEPTH];
  logic             adel_mem_d [BUF_DEPTH];
  assign misalign       = req_pc[1:0] != 2'b00;
  assign push_inst      = inflight_adel_q ? 32'h0 : rom_data_i;
  assign if_excp_adel_o = if_valid_o && adel_mem_q[rd_ptr_q];
`else
  assign misalign  = 1'b0;
  assign push_inst = rom_data_i;
`endif

  assign rom_ce_o   = req && !misalign;
  assign rom_addr_o = rom_ce_o ? req_pc : 32'h0;

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
`ifdef IF_ADEL_CHECK_EN
    adel_mem_d      = adel_mem_q;
    inflight_adel_d = req && misalign;
    if (push) adel_mem_d[wr_ptr_q] = inflight_adel_q;
`endif
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      pc_mem_d[wr_ptr_q]   = inflight_pc_q;
      inst_mem_d[wr_ptr_q] = push_inst;
    end
    if (flush_i) begin
      cnt_d    = '0;
      wr_ptr_d = rd_ptr_q;
    end else if (redirect) begin
      // Only an unpopped head survives; it is the delay slot.
      if (pop || cnt_q == '0) begin
        cnt_d    = '0;
        wr_ptr_d = rd_ptr_d;
      end else begin
        cnt_d    = CW'(1);
        wr_ptr_d = rd_ptr_q + AW'(1);
      end
    end
    inflight_d    = req;
    inflight_pc_d = req ? req_pc : inflight_pc_q;
    if (flush_i)       pc_d = flush_pc_i;
    else if (req)      pc_d = req_pc + 32'(PC_STEP);
    else if (redirect) pc_d = branch_target_i;
    else               pc_d = pc_q;
    if (flush_i || redirect || state_q == IDLE) state_d = FETCH;
    else if (cnt_d + CW'(inflight_d) == CW'(BUF_DEPTH)) state_d = HOLD;
    else state_d = FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_mem_q[i]   <= 32'h0;
        inst_mem_q[i] <= 32'h0;
`ifdef IF_ADEL_CHECK_EN
        adel_mem_q[i] <= 1'b0;
`endif
      end
`ifdef IF_ADEL_CHECK_EN
      inflight_adel_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      pc_mem_q      <= pc_mem_d;
      inst_mem_q    <= inst_mem_d;
`ifdef IF_ADEL_CHECK_EN
      adel_mem_q      <= adel_mem_d;
      inflight_adel_q <= inflight_adel_d;
`endif
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: startup, stall, branch delay slot, flush, async reset.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
`ifdef IF_ADEL_CHECK_EN
  logic        if_excp_adel_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] xq_pc[$];
  logic [31:0] xq_inst[$];

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o)
`ifdef IF_ADEL_CHECK_EN
    ,.if_excp_adel_o(if_excp_adel_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always @(posedge clk) if (rom_ce_o) rom_data_i <= rom_fn(rom_addr_o);

  // Record every instruction handed to IF/ID.
  always @(negedge clk) begin
    #2;
    if (rst && if_valid_o && !stall[1]) begin
      xq_pc.push_back(if_pc_o);
      xq_inst.push_back(if_inst_o);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = '0; branch_flag_i = 0; branch_target_i = '0;
    flush_i = 0; flush_pc_i = '0;
    repeat (3) cyc(); #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", if_inst_o); end
    checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", rom_ce_o); end
    checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", rom_addr_o); end
    xq_pc.delete(); xq_inst.delete();
  endtask

  task automatic test_startup();
    cyc(); rst = 1'b1; #1;
    checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL idle_ce: got %b want 0", rom_ce_o); end
    cyc(); #1;
    checks++; if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL start_req0: got %b/%h want 1/0", rom_ce_o, rom_addr_o); end
    cyc(); #1;
    checks++; if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h4}) begin errors++; $display("FAIL start_req4: got %b/%h want 1/4", rom_ce_o, rom_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL start_bubble: got %b want 0", if_valid_o); end
    cyc(); #1;
    checks++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, rom_fn(32'h0)}) begin errors++; $display("FAIL start_first: got %b/%h/%h want 1/0/%h", if_valid_o, if_pc_o, if_inst_o, rom_fn(32'h0)); end
  endtask

  task automatic test_stall();
    cyc(); stall = 6'b000011; #1;
    checks++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h4}) begin errors++; $display("FAIL stall_head: got %b/%h want 1/4", if_valid_o, if_pc_o); end
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      checks++; if ({if_pc_o, rom_ce_o} !== {32'h4, 1'b0}) begin errors++; $display("FAIL stall_hold%0d: got %h/%b want 4/0", i, if_pc_o, rom_ce_o); end
    end
    cyc(); stall = '0; #1;
    checks++; if ({if_pc_o, if_inst_o, rom_ce_o, rom_addr_o} !== {32'h4, rom_fn(32'h4), 1'b1, 32'hC}) begin errors++; $display("FAIL stall_release: got %h/%h/%b/%h want 4/%h/1/c", if_pc_o, if_inst_o, rom_ce_o, rom_addr_o, rom_fn(32'h4)); end
  endtask

  task automatic test_branch_pop();
    cyc(); branch_flag_i = 1; branch_target_i = 32'h100; #1;
    checks++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h8}) begin errors++; $display("FAIL br_slot: got %b/%h want 1/8", if_valid_o, if_pc_o); end
    checks++; if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h100}) begin errors++; $display("FAIL br_req: got %b/%h want 1/100", rom_ce_o, rom_addr_o); end
    cyc(); branch_flag_i = 0; #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL br_bubble: got %b want 0", if_valid_o); end
    cyc(); #1;
    checks++; if ({if_pc_o, if_inst_o} !== {32'h100, rom_fn(32'h100)}) begin errors++; $display("FAIL br_target: got %h/%h want 100/%h", if_pc_o, if_inst_o, rom_fn(32'h100)); end
  endtask

  task automatic test_branch_stall();
    cyc(); stall = 6'b000010; branch_flag_i = 1; branch_target_i = 32'h200; #1;
    checks++; if ({if_pc_o, rom_ce_o, rom_addr_o} !== {32'h104, 1'b1, 32'h200}) begin errors++; $display("FAIL brs_req: got %h/%b/%h want 104/1/200", if_pc_o, rom_ce_o, rom_addr_o); end
    cyc(); stall = '0; branch_flag_i = 0; #1;
    checks++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h104}) begin errors++; $display("FAIL brs_slot: got %b/%h want 1/104", if_valid_o, if_pc_o); end
    cyc(); #1;
    checks++; if ({if_pc_o, if_inst_o} !== {32'h200, rom_fn(32'h200)}) begin errors++; $display("FAIL brs_target: got %h/%h want 200/%h", if_pc_o, if_inst_o, rom_fn(32'h200)); end
  endtask

  task automatic test_flush();
    logic [31:0] exp_pc [7];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h200, 32'h180};
    cyc(); flush_i = 1; flush_pc_i = 32'h180; branch_flag_i = 1; branch_target_i = 32'h300; #1;
    checks++; if ({if_valid_o, rom_ce_o} !== 2'b00) begin errors++; $display("FAIL fl_cycle: got %b/%b want 0/0", if_valid_o, rom_ce_o); end
    cyc(); flush_i = 0; branch_flag_i = 0; #1;
    checks++; if ({rom_ce_o, rom_addr_o, if_valid_o} !== {1'b1, 32'h180, 1'b0}) begin errors++; $display("FAIL fl_req: got %b/%h/%b want 1/180/0", rom_ce_o, rom_addr_o, if_valid_o); end
    cyc(); #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL fl_bubble: got %b want 0", if_valid_o); end
    cyc(); #1;
    checks++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h180, rom_fn(32'h180)}) begin errors++; $display("FAIL fl_target: got %b/%h/%h want 1/180/%h", if_valid_o, if_pc_o, if_inst_o, rom_fn(32'h180)); end
    #2;
    checks++; if (xq_pc.size() != 7) begin errors++; $display("FAIL xfer_count: got %0d want 7", xq_pc.size()); end
    for (int i = 0; i < 7 && i < xq_pc.size(); i++) begin
      checks++; if ({xq_pc[i], xq_inst[i]} !== {exp_pc[i], rom_fn(exp_pc[i])}) begin errors++; $display("FAIL xfer%0d: got %h/%h want %h/%h", i, xq_pc[i], xq_inst[i], exp_pc[i], rom_fn(exp_pc[i])); end
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #2; rst = 1'b0; #1;
    checks++; if ({if_valid_o, if_pc_o, if_inst_o, rom_ce_o} !== 66'h0) begin errors++; $display("FAIL rst_async: got %b/%h/%h/%b want all 0", if_valid_o, if_pc_o, if_inst_o, rom_ce_o); end
    cyc(); #1;
    checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL rst_noaccess: got %b want 0", rom_ce_o); end
    cyc(); rst = 1'b1;
    cyc(); #1;
    checks++; if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rst_restart: got %b/%h want 1/0", rom_ce_o, rom_addr_o); end
    cyc(); cyc(); #1;
    checks++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, rom_fn(32'h0)}) begin errors++; $display("FAIL rst_first: got %b/%h/%h want 1/0/%h", if_valid_o, if_pc_o, if_inst_o, rom_fn(32'h0)); end
  endtask

  task automatic test_misaligned();
    cyc(); flush_i = 1; flush_pc_i = 32'h102;
    cyc(); flush_i = 0; #1;
`ifdef IF_ADEL_CHECK_EN
    checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL adel_noaccess: got %b want 0", rom_ce_o); end
    cyc(); cyc(); #1;
    checks++; if ({if_valid_o, if_pc_o, if_inst_o, if_excp_adel_o} !== {1'b1, 32'h102, 32'h0, 1'b1}) begin errors++; $display("FAIL adel_entry: got %b/%h/%h/%b want 1/102/0/1", if_valid_o, if_pc_o, if_inst_o, if_excp_adel_o); end
`else
    checks++; if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h102}) begin errors++; $display("FAIL mis_req: got %b/%h want 1/102", rom_ce_o, rom_addr_o); end
    cyc(); cyc(); #1;
    checks++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h102, rom_fn(32'h102)}) begin errors++; $display("FAIL mis_entry: got %b/%h/%h want 1/102/%h", if_valid_o, if_pc_o, if_inst_o, rom_fn(32'h102)); end
`endif
  endtask

  initial begin
    rom_data_i = '0;
    test_reset();
    test_startup();
    test_stall();
    test_branch_pop();
    test_branch_stall();
    test_flush();
    test_reset_midrun();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
